// File: rtl/rgb_fader_n.sv
// Parametrised multi-channel PWM colour sequencer (wheel / breathe / hold).
// Optional square-law gamma on channel duties: define RGB_FADER_GAMMA_EN.
module rgb_fader_n #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned STEP_MAX   = 2_499_999,
  parameter int unsigned DVSR       = 4882
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [1:0]                      mode,
  output logic [CHANNELS-1:0]             pwm_out,
  output logic [$clog2(2*CHANNELS)-1:0]   phase,
  output logic [RESOLUTION:0]             ramp,
  output logic                            done_pulse
);

  localparam int unsigned MAX     = 1 << RESOLUTION;
  localparam int unsigned DUTY_W  = RESOLUTION + 1;
  localparam int unsigned PROD_W  = 2 * DUTY_W;
  localparam int unsigned PH_W    = $clog2(2 * CHANNELS);
  localparam int unsigned NPH     = 2 * CHANNELS;
  localparam int unsigned STEP_W  = (STEP_MAX > 0) ? $clog2(STEP_MAX + 1) : 1;
  localparam int unsigned PRESC_W = (DVSR > 1) ? $clog2(DVSR) : 1;

  localparam logic [DUTY_W-1:0] MAXV = DUTY_W'(MAX);

  logic [PRESC_W-1:0]    presc_cnt;
  logic [RESOLUTION-1:0] pwm_cnt;
  logic                  pwm_tick;

  logic [STEP_W-1:0]     step_cnt, step_n;
  logic [DUTY_W-1:0]     ramp_n;
  logic [PH_W-1:0]       phase_n;
  logic                  done_n;
  logic                  mode_q, mode_n;

  logic                  hold, active, mode_switch, step_tick, up;
  logic [DUTY_W-1:0]     end_val;
  logic [PH_W-1:0]       next_phase;

  logic [PH_W-1:0]       k_c, prev_c;
  logic [DUTY_W-1:0]     duty   [CHANNELS];
  logic [DUTY_W-1:0]     duty_o [CHANNELS];
  logic [CHANNELS-1:0]   pwm_n;

  // PWM time base: prescaler then free-running PWM counter
  assign pwm_tick = (presc_cnt == PRESC_W'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (pwm_tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + RESOLUTION'(1);
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  assign hold        = mode[1];
  assign active      = en && !hold;
  assign mode_switch = !hold && (mode[0] != mode_q);
  assign step_tick   = active && (step_cnt == STEP_W'(STEP_MAX));
  assign up          = ~phase[0];
  assign end_val     = up ? MAXV : '0;

  // Breathe toggles between the two phases; wheel walks all 2*CHANNELS
  always_comb begin
    next_phase = '0;
    if (mode_q) begin
      next_phase = phase[0] ? '0 : PH_W'(1);
    end else if (phase != PH_W'(NPH - 1)) begin
      next_phase = phase + PH_W'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt   <= '0;
      ramp       <= '0;
      phase      <= '0;
      done_pulse <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      step_cnt   <= step_n;
      ramp       <= ramp_n;
      phase      <= phase_n;
      done_pulse <= done_n;
      mode_q     <= mode_n;
    end
  end

  // Sequencer next state
  always_comb begin
    step_n  = step_cnt;
    ramp_n  = ramp;
    phase_n = phase;
    done_n  = 1'b0;
    mode_n  = mode_q;
    if (mode_switch) begin
      step_n  = '0;
      ramp_n  = '0;
      phase_n = '0;
      mode_n  = mode[0];
    end else if (active) begin
      if (step_tick) begin
        step_n = '0;
        if (ramp == end_val) begin
          done_n  = 1'b1;
          phase_n = next_phase;
        end else if (up) begin
          ramp_n = ramp + DUTY_W'(1);
        end else begin
          ramp_n = ramp - DUTY_W'(1);
        end
      end else begin
        step_n = step_cnt + STEP_W'(1);
      end
    end
  end

  // Duty mapping from the (possibly frozen) sequencer state
  always_comb begin
    k_c    = phase >> 1;
    prev_c = (k_c == '0) ? PH_W'(CHANNELS - 1) : k_c - PH_W'(1);
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i] = '0;
      if (mode_q) begin
        duty[i] = ramp;
      end else if (PH_W'(i) == k_c) begin
        duty[i] = phase[0] ? MAXV : ramp;
      end else if (PH_W'(i) == prev_c) begin
        duty[i] = phase[0] ? ramp : MAXV;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
`ifdef RGB_FADER_GAMMA_EN
    logic [PROD_W-1:0] sq;
    assign sq        = PROD_W'(duty[g]) * PROD_W'(duty[g]);
    assign duty_o[g] = DUTY_W'(sq >> RESOLUTION);
`else
    assign duty_o[g] = duty[g];
`endif
    assign pwm_n[g] = (duty_o[g] > {1'b0, pwm_cnt});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_n;
    end
  end

endmodule

// File: tb/tb_rgb_fader_n.sv
// Directed bench for rgb_fader_n with CHANNELS=3, RESOLUTION=2, STEP_MAX=3, DVSR=1.
module tb_rgb_fader_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] pwm_out;
  logic [2:0] phase;
  logic [2:0] ramp;
  logic       done_pulse;

  int n_cmp = 0;
  int n_err = 0;

`ifdef RGB_FADER_GAMMA_EN
  localparam int LO2 = 1;
`else
  localparam int LO2 = 2;
`endif

  rgb_fader_n #(
    .CHANNELS(3), .RESOLUTION(2), .STEP_MAX(3), .DVSR(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .pwm_out(pwm_out), .phase(phase), .ramp(ramp), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mode = 2'd0;
    tick(3);
    n_cmp++; if (pwm_out !== 3'b000) begin n_err++; $display("FAIL reset_pwm got %b want 000", pwm_out); end
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL reset_phase got %0d want 0", phase); end
    n_cmp++; if (ramp !== 3'd0) begin n_err++; $display("FAIL reset_ramp got %0d want 0", ramp); end
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_pulse); end
  endtask

  task automatic test_wheel_ramp;
    rst = 1'b0; en = 1'b1; mode = 2'd0;
    for (int s = 1; s <= 4; s++) begin
      tick(3);
      n_cmp++; if (ramp !== 3'(s - 1)) begin n_err++; $display("FAIL ramp_hold%0d got %0d want %0d", s, ramp, s - 1); end
      tick(1);
      n_cmp++; if (ramp !== 3'(s)) begin n_err++; $display("FAIL ramp_step%0d got %0d want %0d", s, ramp, s); end
    end
    tick(3);
    n_cmp++; if (done_pulse !== 1'b0 || phase !== 3'd0) begin n_err++; $display("FAIL pre_done got done=%b phase=%0d want 0/0", done_pulse, phase); end
    tick(1);
    n_cmp++; if (done_pulse !== 1'b1 || phase !== 3'd1 || ramp !== 3'd4) begin n_err++; $display("FAIL first_done got done=%b phase=%0d ramp=%0d want 1/1/4", done_pulse, phase, ramp); end
    tick(1);
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL done_width got %b want 0", done_pulse); end
    tick(98);
    n_cmp++; if (phase !== 3'd5) begin n_err++; $display("FAIL phase_last got %0d want 5", phase); end
    tick(1);
    n_cmp++; if (phase !== 3'd0 || done_pulse !== 1'b1 || ramp !== 3'd0) begin n_err++; $display("FAIL phase_wrap got phase=%0d done=%b ramp=%0d want 0/1/0", phase, done_pulse, ramp); end
  endtask

  task automatic test_wheel_pwm;
    int cnt [3];
    tick(8);
    n_cmp++; if (ramp !== 3'd2 || phase !== 3'd0) begin n_err++; $display("FAIL p0_state got ramp=%0d phase=%0d want 2/0", ramp, phase); end
    en = 1'b0;
    cnt = '{0, 0, 0};
    for (int c = 0; c < 4; c++) begin
      tick(1);
      for (int ch = 0; ch < 3; ch++) cnt[ch] += int'(pwm_out[ch]);
    end
    n_cmp++; if (cnt[0] !== LO2) begin n_err++; $display("FAIL p0_ch0_high got %0d want %0d", cnt[0], LO2); end
    n_cmp++; if (cnt[1] !== 0) begin n_err++; $display("FAIL p0_ch1_high got %0d want 0", cnt[1]); end
    n_cmp++; if (cnt[2] !== 4) begin n_err++; $display("FAIL p0_ch2_high got %0d want 4", cnt[2]); end
  endtask

  task automatic test_enable_freeze;
    int dones = 0;
    int hi0 = 0;
    for (int c = 0; c < 48; c++) begin
      tick(1);
      dones += int'(done_pulse);
      hi0 += int'(pwm_out[0]);
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL freeze_done got %0d want 0", dones); end
    n_cmp++; if (hi0 !== 12 * LO2) begin n_err++; $display("FAIL freeze_pwm got %0d want %0d", hi0, 12 * LO2); end
    n_cmp++; if (ramp !== 3'd2 || phase !== 3'd0) begin n_err++; $display("FAIL freeze_state got ramp=%0d phase=%0d want 2/0", ramp, phase); end
    en = 1'b1;
    tick(3);
    n_cmp++; if (ramp !== 3'd2) begin n_err++; $display("FAIL resume_hold got %0d want 2", ramp); end
    tick(1);
    n_cmp++; if (ramp !== 3'd3) begin n_err++; $display("FAIL resume_step got %0d want 3", ramp); end
  endtask

  task automatic test_wheel_decay;
    int cnt [3];
    tick(8);
    n_cmp++; if (phase !== 3'd1 || done_pulse !== 1'b1) begin n_err++; $display("FAIL p1_enter got phase=%0d done=%b want 1/1", phase, done_pulse); end
    tick(8);
    n_cmp++; if (ramp !== 3'd2 || phase !== 3'd1) begin n_err++; $display("FAIL p1_state got ramp=%0d phase=%0d want 2/1", ramp, phase); end
    en = 1'b0;
    cnt = '{0, 0, 0};
    for (int c = 0; c < 4; c++) begin
      tick(1);
      for (int ch = 0; ch < 3; ch++) cnt[ch] += int'(pwm_out[ch]);
    end
    n_cmp++; if (cnt[0] !== 4) begin n_err++; $display("FAIL p1_ch0_high got %0d want 4", cnt[0]); end
    n_cmp++; if (cnt[1] !== 0) begin n_err++; $display("FAIL p1_ch1_high got %0d want 0", cnt[1]); end
    n_cmp++; if (cnt[2] !== LO2) begin n_err++; $display("FAIL p1_ch2_high got %0d want %0d", cnt[2], LO2); end
  endtask

  task automatic test_mode_switch;
    en = 1'b1;
    tick(40);
    n_cmp++; if (phase !== 3'd3 || ramp !== 3'd2) begin n_err++; $display("FAIL p3_state got phase=%0d ramp=%0d want 3/2", phase, ramp); end
    mode = 2'd1;
    tick(1);
    n_cmp++; if (phase !== 3'd0 || ramp !== 3'd0 || done_pulse !== 1'b0) begin n_err++; $display("FAIL switch got phase=%0d ramp=%0d done=%b want 0/0/0", phase, ramp, done_pulse); end
    tick(3);
    n_cmp++; if (ramp !== 3'd0) begin n_err++; $display("FAIL switch_step_hold got %0d want 0", ramp); end
    tick(1);
    n_cmp++; if (ramp !== 3'd1) begin n_err++; $display("FAIL switch_step got %0d want 1", ramp); end
  endtask

  task automatic test_breathe;
    logic [2:0] exp_r [9] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic [2:0] exp_p [9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic       exp_d [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int bad = 0;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1);
        if ((pwm_out !== 3'b000 && pwm_out !== 3'b111) || phase > 3'd1) bad++;
      end
      n_cmp++;
      if (ramp !== exp_r[g] || phase !== exp_p[g] || done_pulse !== exp_d[g]) begin
        n_err++;
        $display("FAIL breathe_g%0d got ramp=%0d phase=%0d done=%b want %0d/%0d/%b",
                 g, ramp, phase, done_pulse, exp_r[g], exp_p[g], exp_d[g]);
      end
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL breathe_uniform got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_hold;
    int dones = 0;
    int bad = 0;
    tick(8);
    n_cmp++; if (ramp !== 3'd2) begin n_err++; $display("FAIL hold_pre got %0d want 2", ramp); end
    for (int c = 0; c < 20; c++) begin
      mode = (c < 10) ? 2'd2 : 2'd3;
      tick(1);
      dones += int'(done_pulse);
      if (pwm_out !== 3'b000 && pwm_out !== 3'b111) bad++;
    end
    n_cmp++; if (dones !== 0 || bad !== 0) begin n_err++; $display("FAIL hold_quiet got dones=%0d bad=%0d want 0/0", dones, bad); end
    n_cmp++; if (ramp !== 3'd2 || phase !== 3'd0) begin n_err++; $display("FAIL hold_state got ramp=%0d phase=%0d want 2/0", ramp, phase); end
    mode = 2'd1;
    tick(3);
    n_cmp++; if (ramp !== 3'd2) begin n_err++; $display("FAIL unhold_keep got %0d want 2", ramp); end
    tick(1);
    n_cmp++; if (ramp !== 3'd3 || phase !== 3'd0) begin n_err++; $display("FAIL unhold_step got ramp=%0d phase=%0d want 3/0", ramp, phase); end
  endtask

  task automatic test_reset_mid;
    mode = 2'd0;
    tick(1);
    n_cmp++; if (phase !== 3'd0 || ramp !== 3'd0 || done_pulse !== 1'b0) begin n_err++; $display("FAIL to_wheel got phase=%0d ramp=%0d done=%b want 0/0/0", phase, ramp, done_pulse); end
    tick(80);
    n_cmp++; if (phase !== 3'd4 || done_pulse !== 1'b1) begin n_err++; $display("FAIL p4_enter got phase=%0d done=%b want 4/1", phase, done_pulse); end
    tick(8);
    n_cmp++; if (phase !== 3'd4 || ramp !== 3'd2) begin n_err++; $display("FAIL p4_state got phase=%0d ramp=%0d want 4/2", phase, ramp); end
    rst = 1'b1;
    tick(1);
    n_cmp++; if (pwm_out !== 3'b000 || phase !== 3'd0 || ramp !== 3'd0 || done_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got pwm=%b phase=%0d ramp=%0d done=%b want 000/0/0/0", pwm_out, phase, ramp, done_pulse);
    end
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_wheel_ramp();
    test_wheel_pwm();
    test_enable_freeze();
    test_wheel_decay();
    test_mode_switch();
    test_breathe();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
